reaction_ctrl: RTL

Sequencing controller for the Basys3 reaction timer. It owns the round state machine, the random stimulus delay and the 1 ms timebase. It drives clear/enable into the 4-digit BCD counter that feeds the multiplexed seven-segment display. It also reports early-press, timeout and best-time results to the top level.

---
 rtl/reaction_pkg.sv | 21 ++
 rtl/ms_tick_gen.sv | 28 ++
 rtl/reaction_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-timer sequencing controller.
package reaction_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_TIMING  = 3'd2,
    ST_DONE    = 3'd3,
    ST_EARLY   = 3'd4,
    ST_TIMEOUT = 3'd5
  } state_t;

  localparam logic [15:0] BCD_MAX   = 16'h9999;
  // Fibonacci taps 16,14,13,11 mapped onto bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler; restart marks the current cycle as count 0.
module ms_tick_gen #(
  parameter int unsigned TICK_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int unsigned W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [W-1:0] cnt;
  logic [W-1:0] cnt_eff;

  // restart is high in the first cycle of a state, so that cycle counts as 0
  assign cnt_eff = restart ? '0 : cnt;
  assign tick    = (cnt_eff == W'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= tick ? '0 : cnt_eff + 1'b1;
    end
  end

endmodule

// File: rtl/reaction_ctrl.sv
// Round sequencer for the reaction timer: button sync, random delay,
// ms timebase hookup, BCD counter control and best-time tracking.
module reaction_ctrl
  import reaction_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 100000,
  parameter int unsigned MIN_WAIT_MS = 1000,
  parameter int unsigned RAND_BITS   = 11,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        button,
  input  logic [15:0] count_bcd,
  output logic        cnt_clr,
  output logic        cnt_en,
  output logic        stim_led,
  output logic        early_flag,
  output logic        timeout_flag,
  output logic        result_valid,
  output logic [15:0] best_bcd,
  output logic [2:0]  state_o
);

  localparam int unsigned DELAY_NEED = $clog2(MIN_WAIT_MS + (1 << RAND_BITS) + 1);
  localparam int unsigned DELAY_W    = (DELAY_NEED > 14) ? DELAY_NEED : 14;

  state_t             state;
  logic [1:0]         sync;
  logic               sync_prev;
  logic               press;
  logic [15:0]        lfsr;
  logic [DELAY_W-1:0] delay;
  logic               entry;
  logic               tick;

  ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (entry),
    .tick    (tick)
  );

  assign state_o = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync      <= '0;
      sync_prev <= 1'b0;
      press     <= 1'b0;
      lfsr      <= LFSR_SEED;
    end else begin
      sync      <= {sync[0], button};
      sync_prev <= sync[1];
      press     <= sync[1] & ~sync_prev;
      lfsr      <= lfsr_next(lfsr);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt_clr      <= 1'b0;
      cnt_en       <= 1'b0;
      stim_led     <= 1'b0;
      early_flag   <= 1'b0;
      timeout_flag <= 1'b0;
      result_valid <= 1'b0;
      best_bcd     <= BCD_MAX;
      delay        <= '0;
      entry        <= 1'b0;
    end else begin
      cnt_clr <= 1'b0;
      cnt_en  <= 1'b0;
      entry   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (press) begin
            state   <= ST_WAIT;
            cnt_clr <= 1'b1;
            delay   <= DELAY_W'(MIN_WAIT_MS) + DELAY_W'(lfsr[RAND_BITS-1:0]);
            entry   <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (press) begin
            state      <= ST_EARLY;
            early_flag <= 1'b1;
            entry      <= 1'b1;
          end else if (tick) begin
            delay <= delay - 1'b1;
            if (delay <= DELAY_W'(1)) begin
              state    <= ST_TIMING;
              stim_led <= 1'b1;
              entry    <= 1'b1;
            end
          end
        end
        ST_TIMING: begin
          if (press) begin
            state        <= ST_DONE;
            stim_led     <= 1'b0;
            result_valid <= 1'b1;
            entry        <= 1'b1;
          end else if (count_bcd == BCD_MAX) begin
            state        <= ST_TIMEOUT;
            stim_led     <= 1'b0;
            timeout_flag <= 1'b1;
            entry        <= 1'b1;
          end else begin
            cnt_en <= tick;
          end
        end
        ST_DONE, ST_EARLY, ST_TIMEOUT: begin
          // Compare on the first DONE cycle so a last in-flight increment is seen
          if (state == ST_DONE && entry && count_bcd < best_bcd) begin
            best_bcd <= count_bcd;
          end
          if (press) begin
            state        <= ST_IDLE;
            cnt_clr      <= 1'b1;
            early_flag   <= 1'b0;
            timeout_flag <= 1'b0;
            result_valid <= 1'b0;
            entry        <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
